thirty_two_bit_adder: RTL and testbench

//   32-bit ripple-carry adder with carry-in/carry-out and a registered output stage.

---
 rtl/thirty_two_bit_adder_pkg.sv | 11 +
 rtl/thirty_two_bit_adder_full_adder.sv | 18 +
 rtl/thirty_two_bit_adder.sv | 54 +++++
 tb/tb_thirty_two_bit_adder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/thirty_two_bit_adder_pkg.sv
// Shared constants and result payload type for the ripple-carry adder.
package thirty_two_bit_adder_pkg;

    localparam int unsigned ADDER_WIDTH = 32;

    typedef struct packed {
        logic                   cout;
        logic [ADDER_WIDTH-1:0] sum;
    } add_result_t;

endpackage : thirty_two_bit_adder_pkg

// File: rtl/thirty_two_bit_adder_full_adder.sv
// Single-bit full adder cell; chained by the top to form the ripple carry path.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    always_comb begin
        p    = a ^ b;
        s    = p ^ cin;
        cout = (a & b) | (cin & p);
    end

endmodule : full_adder

// File: rtl/thirty_two_bit_adder.sv
// Ripple-carry adder with carry-in/out and a one-cycle registered output stage.
module thirty_two_bit_adder
    import thirty_two_bit_adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;

    assign c[0] = cin;

    // Carry ripples from bit 0 upward through one cell per bit.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    always_comb begin
        sum_d  = s;
        cout_d = c[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : thirty_two_bit_adder

// File: tb/tb_thirty_two_bit_adder.sv
// Scoreboard bench: expected {cout,sum} queued at drive time, checked one edge later.
module tb_thirty_two_bit_adder;
    import thirty_two_bit_adder_pkg::*;

    localparam int unsigned W = ADDER_WIDTH;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;

    add_result_t  exp_q[$];
    add_result_t  last_exp;
    int           n_checks;
    int           n_errors;

    thirty_two_bit_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input add_result_t got, input add_result_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got cout=%0b sum=%08h, expected cout=%0b sum=%08h",
                     tag, got.cout, got.sum, exp.cout, exp.sum);
        end
    endtask

    // Drive one operation, push its reference result, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic vc);
        logic [W:0]  ref_full;
        add_result_t e;
        add_result_t got;
        rst = r;
        a   = va;
        b   = vb;
        cin = vc;
        ref_full = {1'b0, va} + {1'b0, vb} + (W+1)'(vc);
        e = r ? add_result_t'('0) : add_result_t'(ref_full);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got.cout = cout;
        got.sum  = sum;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty when output appeared", tag);
        end else begin
            last_exp = exp_q.pop_front();
            check_eq(tag, got, last_exp);
        end
    endtask

    initial begin
        add_result_t got;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        @(negedge clk);

        step("reset0", 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        step("reset1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        step("add10_10",   1'b0, 32'd10,   32'd10,   1'b0);
        step("a200",       1'b0, 32'd200,  32'd10,   1'b0);
        step("b750",       1'b0, 32'd200,  32'd750,  1'b0);
        step("a1234",      1'b0, 32'd1234, 32'd750,  1'b0);
        step("b5678",      1'b0, 32'd1234, 32'd5678, 1'b0);

        step("wrap_plus1", 1'b0, 32'hFFFF_FFFF, 32'd1,          1'b0);
        step("wrap_all1",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step("cin_only",   1'b0, 32'd0,         32'd0,         1'b1);
        step("msb_msb",    1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        step("alt_bits",   1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);

        // Inputs moving between edges must not disturb the held outputs.
        a   = 32'h0F0F_0F0F;
        b   = 32'h7777_7777;
        cin = 1'b1;
        #3;
        got.cout = cout;
        got.sum  = sum;
        check_eq("hold", got, last_exp);

        // Back-to-back stream with a mid-stream reset pulse.
        step("bb0",       1'b0, 32'd1,         32'd2,         1'b0);
        step("bb1",       1'b0, 32'd100,       32'd200,       1'b1);
        step("mid_reset", 1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b0);
        step("resume",    1'b0, 32'd7,         32'd8,         1'b1);
        step("bb2",       1'b0, 32'h7FFF_FFFF, 32'd1,         1'b0);

        for (int i = 0; i < 10000; i++) begin
            step("rand", 1'b0, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left in scoreboard, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_thirty_two_bit_adder
